// File: rtl/multicycle_ex_ctrl_pkg.sv
// rtl/multicycle_ex_ctrl_pkg.sv - unit codes, subop bits, FSM states and helpers for multicycle_ex_ctrl
// Holds the decode constants shared between the EX decoder and the
// multicycle controller, the controller state encoding and a magnitude helper.
package multicycle_ex_ctrl_pkg;

  // ex_operation[8:6] unit codes
  localparam logic [2:0] EX_UNIT_TX  = 3'b001;
  localparam logic [2:0] EX_UNIT_DIV = 3'b011;

  // Divide subop bit positions in ex_operation[5:0]
  localparam int SUBOP_SIGNED_BIT = 0;
  localparam int SUBOP_REM_BIT    = 1;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_DIV_RUN = 3'd1,
    ST_DIV_FIX = 3'd2,
    ST_TX_WAIT = 3'd3,
    ST_DONE    = 3'd4
  } ex_state_t;

  // Absolute value when the operand is treated as signed; 32'h8000_0000
  // maps onto itself, which is the correct unsigned magnitude.
  function automatic logic [31:0] magnitude(input logic [31:0] v, input logic is_signed);
    return (is_signed && v[31]) ? -v : v;
  endfunction

endpackage

// File: rtl/multicycle_ex_ctrl_if.sv
// rtl/multicycle_ex_ctrl_if.sv - EX-stage issue/result/TX bundle for multicycle_ex_ctrl
// master: pipeline side (drives issue_valid, ex_operation, op_a, op_b, rd_addr,
//         flush, tx_ready; observes stall, result*, tx_valid, tx_data)
// slave:  multicycle_ex_ctrl side (the reverse directions)
interface multicycle_ex_ctrl_if #(
  parameter int XLEN = 32
);
  logic            issue_valid;
  logic [9:0]      ex_operation;
  logic [XLEN-1:0] op_a;
  logic [XLEN-1:0] op_b;
  logic [4:0]      rd_addr;
  logic            flush;
  logic            stall;
  logic            result_valid;
  logic [XLEN-1:0] result;
  logic [4:0]      result_rd_addr;
  logic            tx_valid;
  logic [XLEN-1:0] tx_data;
  logic            tx_ready;

  modport master (
    output issue_valid, ex_operation, op_a, op_b, rd_addr, flush, tx_ready,
    input  stall, result_valid, result, result_rd_addr, tx_valid, tx_data
  );

  modport slave (
    input  issue_valid, ex_operation, op_a, op_b, rd_addr, flush, tx_ready,
    output stall, result_valid, result, result_rd_addr, tx_valid, tx_data
  );
endinterface

// File: rtl/multicycle_ex_ctrl_div_core.sv
// rtl/multicycle_ex_ctrl_div_core.sv - iterative restoring unsigned divider datapath
// Ports: clk, rst (sync, active high), start (load operands, clear counter),
//        step_en (one restoring step), dividend, divisor, quotient, remainder,
//        done (high during the final step).
module multicycle_ex_ctrl_div_core #(
  parameter int WIDTH = 32,
  parameter int STEPS = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             step_en,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             done
);
  localparam int CW = $clog2(STEPS);
  localparam logic [CW-1:0] LAST = CW'(STEPS - 1);

  logic [WIDTH-1:0] rem_q;
  logic [WIDTH-1:0] quo_q;   // dividend shifts out the top, quotient bits enter the bottom
  logic [WIDTH-1:0] dvs_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   trial;

  // shifted < 2*divisor, so a non-negative trial always fits in WIDTH bits
  // and trial[WIDTH] is a clean borrow flag.
  always_comb begin
    shifted = {rem_q, quo_q[WIDTH-1]};
    trial   = shifted - {1'b0, dvs_q};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rem_q <= '0;
      quo_q <= '0;
      dvs_q <= '0;
      cnt_q <= '0;
    end else if (start) begin
      rem_q <= '0;
      quo_q <= dividend;
      dvs_q <= divisor;
      cnt_q <= '0;
    end else if (step_en) begin
      if (!trial[WIDTH]) begin
        rem_q <= trial[WIDTH-1:0];
        quo_q <= {quo_q[WIDTH-2:0], 1'b1};
      end else begin
        rem_q <= shifted[WIDTH-1:0];
        quo_q <= {quo_q[WIDTH-2:0], 1'b0};
      end
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign done      = step_en && (cnt_q == LAST);
  assign quotient  = quo_q;
  assign remainder = rem_q;
endmodule

// File: rtl/multicycle_ex_ctrl.sv
// rtl/multicycle_ex_ctrl.sv - EX-stage sequencer for multi-cycle divide and TX ops
// Ports: clk, rst (sync, active high), bus (multicycle_ex_ctrl_if.slave):
//   issue_valid/ex_operation/op_a/op_b/rd_addr in, flush in, stall out,
//   result_valid/result/result_rd_addr out, tx_valid/tx_data out, tx_ready in.
// Optional: DIV_EARLY_OUT_EN - skip the iterative divide when |op_a| < |op_b|.
module multicycle_ex_ctrl
  import multicycle_ex_ctrl_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter int DIV_STEPS = 32
) (
  input logic                clk,
  input logic                rst,
  multicycle_ex_ctrl_if.slave bus
);
  ex_state_t       state_q;
  logic            signed_q, rem_sel_q, neg_a_q, neg_b_q, early_q;
  logic [XLEN-1:0] mag_a_q;

  logic [2:0]      unit;
  logic            is_div, is_tx, accept;
  logic            sgn, want_rem, a_neg, b_neg;
  logic [XLEN-1:0] abs_a, abs_b;
  logic            div_zero, overflow, early_out, core_start;
  logic [XLEN-1:0] special_res;
  logic [XLEN-1:0] core_q, core_r, q_raw, r_raw, q_fix, r_fix;
  logic            core_done;
  logic            unused_subop_bits;

  assign unused_subop_bits = ^bus.ex_operation[5:2];

  assign unit   = bus.ex_operation[8:6];
  assign is_div = (unit == EX_UNIT_DIV);
  assign is_tx  = (unit == EX_UNIT_TX);
  assign accept = (state_q == ST_IDLE) && bus.issue_valid && bus.ex_operation[9]
                  && (is_div || is_tx) && !bus.flush;

  assign sgn      = bus.ex_operation[SUBOP_SIGNED_BIT];
  assign want_rem = bus.ex_operation[SUBOP_REM_BIT];
  assign a_neg    = sgn && bus.op_a[XLEN-1];
  assign b_neg    = sgn && bus.op_b[XLEN-1];
  assign abs_a    = magnitude(bus.op_a, sgn);
  assign abs_b    = magnitude(bus.op_b, sgn);

  assign div_zero = (bus.op_b == '0);
  assign overflow = sgn && (bus.op_a == 32'h8000_0000) && (bus.op_b == 32'hFFFF_FFFF);

  // Special cases answer directly from the operands without touching the core.
  always_comb begin
    special_res = '0;
    if (div_zero) special_res = want_rem ? bus.op_a : 32'hFFFF_FFFF;
    else          special_res = want_rem ? 32'h0 : 32'h8000_0000;
  end

`ifdef DIV_EARLY_OUT_EN
  assign early_out = !div_zero && (abs_a < abs_b);
`else
  assign early_out = 1'b0;
`endif

  assign core_start = accept && is_div && !div_zero && !overflow && !early_out;

  multicycle_ex_ctrl_div_core #(
    .WIDTH (XLEN),
    .STEPS (DIV_STEPS)
  ) u_div_core (
    .clk       (clk),
    .rst       (rst),
    .start     (core_start),
    .step_en   (state_q == ST_DIV_RUN),
    .dividend  (abs_a),
    .divisor   (abs_b),
    .quotient  (core_q),
    .remainder (core_r),
    .done      (core_done)
  );

  // Early-out bypasses the core: quotient 0, remainder is the dividend magnitude.
  always_comb begin
    q_raw = early_q ? '0 : core_q;
    r_raw = early_q ? mag_a_q : core_r;
    q_fix = (signed_q && (neg_a_q ^ neg_b_q)) ? -q_raw : q_raw;
    r_fix = (signed_q && neg_a_q) ? -r_raw : r_raw;
  end

  // Combinational so the front end freezes in the very cycle the op is accepted;
  // low in DONE so the pipeline advances with result_valid.
  assign bus.stall = accept ||
                     (state_q == ST_DIV_RUN) || (state_q == ST_DIV_FIX) || (state_q == ST_TX_WAIT);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q            <= ST_IDLE;
      signed_q           <= 1'b0;
      rem_sel_q          <= 1'b0;
      neg_a_q            <= 1'b0;
      neg_b_q            <= 1'b0;
      early_q            <= 1'b0;
      mag_a_q            <= '0;
      bus.result_valid   <= 1'b0;
      bus.result         <= '0;
      bus.result_rd_addr <= '0;
      bus.tx_valid       <= 1'b0;
      bus.tx_data        <= '0;
    end else begin
      bus.result_valid <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            if (is_div) begin
              signed_q           <= sgn;
              rem_sel_q          <= want_rem;
              neg_a_q            <= a_neg;
              neg_b_q            <= b_neg;
              mag_a_q            <= abs_a;
              early_q            <= early_out;
              bus.result_rd_addr <= bus.rd_addr;
              if (div_zero || overflow) begin
                bus.result       <= special_res;
                bus.result_valid <= 1'b1;
                state_q          <= ST_DONE;
              end else if (early_out) begin
                state_q <= ST_DIV_FIX;
              end else begin
                state_q <= ST_DIV_RUN;
              end
            end else begin
              bus.tx_data  <= bus.op_b;
              bus.tx_valid <= 1'b1;
              state_q      <= ST_TX_WAIT;
            end
          end
        end
        ST_DIV_RUN: begin
          if (bus.flush)     state_q <= ST_IDLE;
          else if (core_done) state_q <= ST_DIV_FIX;
        end
        ST_DIV_FIX: begin
          if (bus.flush) begin
            state_q <= ST_IDLE;
          end else begin
            bus.result       <= rem_sel_q ? r_fix : q_fix;
            bus.result_valid <= 1'b1;
            state_q          <= ST_DONE;
          end
        end
        ST_TX_WAIT: begin
          // A handshake coinciding with flush has already been delivered.
          if (bus.flush || bus.tx_ready) begin
            bus.tx_valid <= 1'b0;
            state_q      <= ST_IDLE;
          end
        end
        ST_DONE: state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: doc/multicycle_ex_ctrl.md
Name: multicycle_ex_ctrl

Overview:
- Sequences multi-cycle execute operations flagged by ex_operation[9]=1.
- Supported units:
  - Unit 011: iterative 32-bit divide/remainder.
  - Unit 001: TX, which sends an operand to an external transmit port.
- Sits beside the single-cycle ALU in EX. Stalls the front of the pipeline while busy and returns one result with its rd address when done.

Parameters:
- XLEN, 32, operand/result width; only 32 supported.
- DIV_STEPS, 32, quotient bits produced per division; must equal XLEN.

Ports:
- clk  input  1  clock.
- rst  input  1  synchronous active-high reset.
- issue_valid  input  1  EX holds a valid instruction this cycle.
- ex_operation  input  10  decoded op: [9] multicycle, [8:6] unit, [5:0] subop.
- op_a  input  32  rs1 value (dividend).
- op_b  input  32  rs2 value (divisor / TX data).
- rd_addr  input  5  destination register of the issued op.
- flush  input  1  abort in-flight op (branch/jump redirect).
- stall  output  1  hold IF/ID/EX stage registers.
- result_valid  output  1  one-cycle pulse; result/result_rd_addr valid.
- result  output  32  quotient or remainder.
- result_rd_addr  output  5  rd of completed op.
- tx_valid  output  1  TX data offered.
- tx_data  output  32  TX payload.
- tx_ready  input  1  TX sink accepts when tx_valid&tx_ready.

Behaviour:

Acceptance:
- Accept = state IDLE & issue_valid & ex_operation[9] & unit in {011, 001} & !flush.
- Any other op, including [9]=1 with an unknown unit, is ignored. stall stays 0 for it.

Divide subop (unit 011):
- Bit0 = signed. Bit1 = return remainder.
- 000 divu, 001 div, 010 remu, 011 rem.

Reset values:
- state=IDLE; stall, result_valid, tx_valid = 0.
- result, result_rd_addr, tx_data = 0.

States:
- IDLE, DIV_RUN, DIV_FIX, TX_WAIT, DONE.

stall:
- Combinational.
- High in IDLE when accept is true.
- High in DIV_RUN, DIV_FIX, TX_WAIT.
- Low in DONE, so the pipeline advances the same cycle result_valid pulses.

Divide sequence:
- Cycle 0 (accept):
  - Latch |op_a|, |op_b|, signs, subop, rd_addr.
  - Go to DIV_RUN with step counter = 0.
- DIV_RUN:
  - One restoring step per cycle, 32 cycles (counter 0..31).
  - Then go to DIV_FIX.
- DIV_FIX:
  - Negate quotient if signed & sign(a)^sign(b).
  - Negate remainder if signed & sign(a).
  - Go to DONE.
- DONE:
  - result_valid=1, go to IDLE.
  - Normal latency: accept cycle 0, result_valid in cycle 34.

Divide special cases (accept goes straight to DONE; result_valid in cycle 1):
- Divide by zero: quotient = 32'hFFFF_FFFF, remainder = op_a (signed and unsigned).
- Signed overflow (op_a = 32'h8000_0000, op_b = 32'hFFFF_FFFF): quotient = 32'h8000_0000, remainder = 0.

TX sequence:
- Accept: tx_data <= op_b, tx_valid <= 1, go to TX_WAIT.
- TX_WAIT:
  - Hold tx_data stable while tx_valid=1.
  - On tx_ready: tx_valid <= 0, go to IDLE.
  - No result_valid is produced (TX has no rd).

flush:
- In any non-IDLE state: go to IDLE next cycle.
- No result_valid. tx_valid drops.
- A transfer already completing in the same cycle (tx_valid&tx_ready) still counts as sent.
- flush has priority over accept.

Back-to-back ops:
- A new accept is possible only in IDLE, i.e. one cycle after DONE or after the TX handshake.

rst:
- Mid-operation, rst abandons everything and forces reset values next edge.

Optional Feature:
- Macro: DIV_EARLY_OUT_EN.
- Defined: at accept, if |op_a| < |op_b| (unsigned compare of magnitudes, divisor nonzero), skip DIV_RUN.
  - Go to DIV_FIX with quotient = 0, remainder = |op_a|.
  - result_valid in cycle 2.
- Undefined: all non-special divisions take the full 34-cycle latency.

Decomposition:
- Shared header ex_ops.v holds:
  - Unit codes: EX_UNIT_TX=3'b001, EX_UNIT_DIV=3'b011.
  - Divide subop bit positions (signed=0, rem=1).
  - State encoding constants.
- The decoder and this block both include it.
- One sub-module, div_core: iterative restoring divider datapath.
  - Holds the remainder/quotient shift registers and counter.
  - Interface: start, step enable, done.
  - multicycle_ex_ctrl keeps the FSM, sign handling, special cases and TX.

Test Plan:
1. div: op_a=-7 (32'hFFFF_FFF9), op_b=2, subop 001 -> stall high cycles 0–33; result_valid cycle 34, result=32'hFFFF_FFFD (-3).
2. rem/remu: op_a=-7, op_b=2, subop 011 -> result=32'hFFFF_FFFF (-1). Same operands, subop 010 -> result=1.
3. Special cases:
   - divu by zero, op_a=100 -> result=32'hFFFF_FFFF, result_valid cycle 1.
   - rem by zero -> 100.
   - div 32'h8000_0000 / -1 -> 32'h8000_0000.
4. TX: op_b=32'hDEAD_BEEF, tx_ready held 0 for 5 cycles, then 1 -> tx_valid and tx_data stable throughout; stall high until the handshake cycle; no result_valid.
5. flush at cycle 10 of a div -> IDLE at cycle 11, no result_valid. A new div accepted at cycle 11 completes at cycle 45.
6. Non-multicycle op (ex_operation=10'b0_000_000000) with issue_valid -> stall 0, no state change. With DIV_EARLY_OUT_EN, divu 3/10 -> result_valid cycle 2, result=0; remu 3/10 -> result=3.
